id_stage_hz: RTL and testbench

- Parametrised MIPS instruction-decode stage, next generation of the ID block.
- Takes the IF/ID instruction and PC+4, reads a 2R1W register bank with write-through from WB, and decodes control.
- Resolves BEQ/BNE/J/JAL in ID and detects load-use and branch-operand hazards.
- Drives a registered ID/EX pipeline bank with stall, bubble and flush support.

---
 rtl/mips_pkg.sv | 96 +++++++++
 rtl/id_stage_hz_if.sv | 57 +++++
 rtl/regbank_2r1w.sv | 40 ++++
 rtl/id_stage_hz.sv | 151 +++++++++++++++
 tb/tb_id_stage_hz.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS decode constants, control bundle and opcode helpers for the ID stage.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam int unsigned LINK_REG = 31;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_LOGIC = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    EXT_SIGN,
    EXT_ZERO,
    EXT_UPPER
  } ext_e;

  typedef struct packed {
    logic    reg_dst;
    logic    alu_src;
    logic    mem2reg;
    logic    mem_read;
    logic    mem_write;
    logic    reg_write;
    logic    link;
    alu_op_e alu_op;
  } ctrl_t;

  // Unknown opcodes fall through to an all-zero control word, i.e. a NOP.
  function automatic ctrl_t decode_ctrl(input logic [5:0] op);
    ctrl_t c;
    c = '0;
    c.alu_op = ALUOP_ADD;
    case (op)
      OP_RTYPE: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
        c.alu_op    = ALUOP_RTYPE;
      end
      OP_JAL: begin
        c.link      = 1'b1;
        c.reg_write = 1'b1;
      end
      OP_BEQ, OP_BNE: c.alu_op = ALUOP_SUB;
      OP_ADDI, OP_LUI: begin
        c.alu_src   = 1'b1;
        c.reg_write = 1'b1;
      end
      OP_ANDI, OP_ORI: begin
        c.alu_src   = 1'b1;
        c.reg_write = 1'b1;
        c.alu_op    = ALUOP_LOGIC;
      end
      OP_LW: begin
        c.alu_src   = 1'b1;
        c.mem2reg   = 1'b1;
        c.mem_read  = 1'b1;
        c.reg_write = 1'b1;
      end
      OP_SW: begin
        c.alu_src   = 1'b1;
        c.mem_write = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic ext_e ext_kind(input logic [5:0] op);
    case (op)
      OP_ANDI, OP_ORI: return EXT_ZERO;
      OP_LUI:          return EXT_UPPER;
      default:         return EXT_SIGN;
    endcase
  endfunction

endpackage

// File: rtl/id_stage_hz_if.sv
// IF/ID, WB, hazard-source and ID/EX signal bundle for the ID stage.
interface id_stage_hz_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int PC_W   = 32
);
  logic [31:0]       i_instruction;
  logic [PC_W-1:0]   i_pcounter4;
  logic              i_stall;
  logic              i_flush;
  logic              i_we_wb;
  logic [REG_AW-1:0] i_wr_addr_wb;
  logic [DATA_W-1:0] i_wr_data_wb;
  logic              i_ex_mem_read;
  logic              i_ex_reg_write;
  logic [REG_AW-1:0] i_ex_wr_addr;
  logic              i_mem_reg_write;
  logic [REG_AW-1:0] i_mem_wr_addr;
  logic [DATA_W-1:0] i_mem_wr_data;

  logic              o_hz_stall;
  logic              o_pc_src;
  logic [PC_W-1:0]   o_pc_target;
  logic [REG_AW-1:0] o_rs;
  logic [REG_AW-1:0] o_rt;
  logic [REG_AW-1:0] o_rd;
  logic [DATA_W-1:0] o_reg_DA;
  logic [DATA_W-1:0] o_reg_DB;
  logic [DATA_W-1:0] o_immediate;
  logic [4:0]        o_shamt;
  logic [5:0]        o_func;
  logic              o_regDst;
  logic              o_aluSrc;
  logic              o_mem2Reg;
  logic              o_memRead;
  logic              o_memWrite;
  logic              o_regWrite;
  logic              o_link;
  logic [1:0]        o_aluOp;
  logic [PC_W-1:0]   o_link_pc;

  modport master (
    output i_instruction, i_pcounter4, i_stall, i_flush, i_we_wb, i_wr_addr_wb, i_wr_data_wb,
           i_ex_mem_read, i_ex_reg_write, i_ex_wr_addr, i_mem_reg_write, i_mem_wr_addr, i_mem_wr_data,
    input  o_hz_stall, o_pc_src, o_pc_target, o_rs, o_rt, o_rd, o_reg_DA, o_reg_DB, o_immediate,
           o_shamt, o_func, o_regDst, o_aluSrc, o_mem2Reg, o_memRead, o_memWrite, o_regWrite,
           o_link, o_aluOp, o_link_pc
  );

  modport slave (
    input  i_instruction, i_pcounter4, i_stall, i_flush, i_we_wb, i_wr_addr_wb, i_wr_data_wb,
           i_ex_mem_read, i_ex_reg_write, i_ex_wr_addr, i_mem_reg_write, i_mem_wr_addr, i_mem_wr_data,
    output o_hz_stall, o_pc_src, o_pc_target, o_rs, o_rt, o_rd, o_reg_DA, o_reg_DB, o_immediate,
           o_shamt, o_func, o_regDst, o_aluSrc, o_mem2Reg, o_memRead, o_memWrite, o_regWrite,
           o_link, o_aluOp, o_link_pc
  );
endinterface

// File: rtl/regbank_2r1w.sv
// Two-read one-write register bank; register 0 reads zero, reset clears every entry.
module regbank_2r1w #(
  parameter int DATA_W = 32,
  parameter int NB_REG = 32,
  parameter int AW     = $clog2(NB_REG)
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr_a,
  input  logic [AW-1:0]     i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_a,
  output logic [DATA_W-1:0] o_rdata_b
);

  logic [DATA_W-1:0] regs_q [NB_REG];
  logic [DATA_W-1:0] regs_d [NB_REG];
  logic              wr_en;

  assign wr_en = i_we && (i_waddr != '0);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[i_waddr] = i_wdata;
  end

  always_ff @(posedge clk) begin
    if (i_rst) regs_q <= '{default: '0};
    else       regs_q <= regs_d;
  end

  // Same-cycle WB data bypasses the array so ID never sees a stale operand.
  assign o_rdata_a = (i_raddr_a == '0)                    ? '0      :
                     (wr_en && (i_waddr == i_raddr_a))    ? i_wdata : regs_q[i_raddr_a];
  assign o_rdata_b = (i_raddr_b == '0)                    ? '0      :
                     (wr_en && (i_waddr == i_raddr_b))    ? i_wdata : regs_q[i_raddr_b];

endmodule

// File: rtl/id_stage_hz.sv
// MIPS ID stage: register read, decode, ID-resolved branches/jumps, hazard stall and ID/EX bank.
// Define ID_BRANCH_FWD_EN to forward the MEM result into the branch comparator instead of stalling.
module id_stage_hz
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NB_REG = 32,
  parameter int REG_AW = 5,
  parameter int PC_W   = 32
) (
  input logic          clk,
  input logic          i_rst,
  id_stage_hz_if.slave bus
);

  typedef struct packed {
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] reg_da;
    logic [DATA_W-1:0] reg_db;
    logic [DATA_W-1:0] immediate;
    logic [4:0]        shamt;
    logic [5:0]        func;
    ctrl_t             ctrl;
    logic [PC_W-1:0]   link_pc;
  } id_ex_t;

  logic [31:0]       instr;
  logic [5:0]        opcode;
  logic [REG_AW-1:0] rs, rt, rd_field;
  logic [15:0]       imm16;
  logic [PC_W-1:0]   pc4;
  logic              is_beq, is_bne, is_branch, is_jump, reads_rt;
  logic [DATA_W-1:0] rdata_a, rdata_b, cmp_a, cmp_b, imm_ext;
  logic              ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
  logic              ex_load_hit, ex_branch_hit, mem_branch_hit, hz_stall;
  logic [PC_W-1:0]   br_target, jmp_target;
  id_ex_t            decoded, id_ex_d, id_ex_q;

  assign instr     = bus.i_instruction;
  assign opcode    = instr[31:26];
  assign rs        = REG_AW'(instr[25:21]);
  assign rt        = REG_AW'(instr[20:16]);
  assign rd_field  = REG_AW'(instr[15:11]);
  assign imm16     = instr[15:0];
  assign pc4       = bus.i_pcounter4;
  assign is_beq    = (opcode == OP_BEQ);
  assign is_bne    = (opcode == OP_BNE);
  assign is_branch = is_beq || is_bne;
  assign is_jump   = (opcode == OP_J) || (opcode == OP_JAL);
  assign reads_rt  = (opcode == OP_RTYPE) || is_branch || (opcode == OP_SW);

  regbank_2r1w #(
    .DATA_W (DATA_W),
    .NB_REG (NB_REG),
    .AW     (REG_AW)
  ) u_regbank (
    .clk       (clk),
    .i_rst     (i_rst),
    .i_we      (bus.i_we_wb),
    .i_waddr   (bus.i_wr_addr_wb),
    .i_wdata   (bus.i_wr_data_wb),
    .i_raddr_a (rs),
    .i_raddr_b (rt),
    .o_rdata_a (rdata_a),
    .o_rdata_b (rdata_b)
  );

  assign ex_hit_rs  = (bus.i_ex_wr_addr != '0) && (bus.i_ex_wr_addr == rs);
  assign ex_hit_rt  = (bus.i_ex_wr_addr != '0) && (bus.i_ex_wr_addr == rt);
  assign mem_hit_rs = (bus.i_mem_wr_addr != '0) && (bus.i_mem_wr_addr == rs);
  assign mem_hit_rt = (bus.i_mem_wr_addr != '0) && (bus.i_mem_wr_addr == rt);

  assign ex_load_hit   = bus.i_ex_mem_read && (ex_hit_rs || (reads_rt && ex_hit_rt));
  assign ex_branch_hit = is_branch && bus.i_ex_reg_write && (ex_hit_rs || ex_hit_rt);

`ifdef ID_BRANCH_FWD_EN
  assign mem_branch_hit = 1'b0;
  assign cmp_a = (bus.i_mem_reg_write && mem_hit_rs) ? bus.i_mem_wr_data : rdata_a;
  assign cmp_b = (bus.i_mem_reg_write && mem_hit_rt) ? bus.i_mem_wr_data : rdata_b;
`else
  logic unused_mem_data;
  assign unused_mem_data = ^bus.i_mem_wr_data;
  assign mem_branch_hit  = is_branch && bus.i_mem_reg_write && (mem_hit_rs || mem_hit_rt);
  assign cmp_a = rdata_a;
  assign cmp_b = rdata_b;
`endif

  assign hz_stall   = ex_load_hit || ex_branch_hit || mem_branch_hit;
  assign br_target  = pc4 + {{(PC_W-18){imm16[15]}}, imm16, 2'b00};
  assign jmp_target = {pc4[PC_W-1:28], instr[25:0], 2'b00};

  assign bus.o_hz_stall  = hz_stall;
  assign bus.o_pc_target = is_jump ? jmp_target : br_target;
  assign bus.o_pc_src    = !hz_stall && ((is_beq && (cmp_a == cmp_b)) ||
                                         (is_bne && (cmp_a != cmp_b)) || is_jump);

  always_comb begin
    case (ext_kind(opcode))
      EXT_ZERO:  imm_ext = {{(DATA_W-16){1'b0}}, imm16};
      EXT_UPPER: imm_ext = {imm16, {(DATA_W-16){1'b0}}};
      default:   imm_ext = {{(DATA_W-16){imm16[15]}}, imm16};
    endcase
  end

  always_comb begin
    decoded           = '0;
    decoded.rs        = rs;
    decoded.rt        = rt;
    decoded.rd        = (opcode == OP_JAL) ? REG_AW'(LINK_REG) : rd_field;
    decoded.reg_da    = rdata_a;
    decoded.reg_db    = rdata_b;
    decoded.immediate = imm_ext;
    decoded.shamt     = instr[10:6];
    decoded.func      = instr[5:0];
    decoded.ctrl      = decode_ctrl(opcode);
    decoded.link_pc   = pc4;
  end

  // Bubbles (flush or own hazard) outrank the downstream hold.
  always_comb begin
    id_ex_d = id_ex_q;
    if (bus.i_flush || hz_stall) id_ex_d = '0;
    else if (!bus.i_stall)       id_ex_d = decoded;
  end

  always_ff @(posedge clk) begin
    if (i_rst) id_ex_q <= '0;
    else       id_ex_q <= id_ex_d;
  end

  assign bus.o_rs        = id_ex_q.rs;
  assign bus.o_rt        = id_ex_q.rt;
  assign bus.o_rd        = id_ex_q.rd;
  assign bus.o_reg_DA    = id_ex_q.reg_da;
  assign bus.o_reg_DB    = id_ex_q.reg_db;
  assign bus.o_immediate = id_ex_q.immediate;
  assign bus.o_shamt     = id_ex_q.shamt;
  assign bus.o_func      = id_ex_q.func;
  assign bus.o_regDst    = id_ex_q.ctrl.reg_dst;
  assign bus.o_aluSrc    = id_ex_q.ctrl.alu_src;
  assign bus.o_mem2Reg   = id_ex_q.ctrl.mem2reg;
  assign bus.o_memRead   = id_ex_q.ctrl.mem_read;
  assign bus.o_memWrite  = id_ex_q.ctrl.mem_write;
  assign bus.o_regWrite  = id_ex_q.ctrl.reg_write;
  assign bus.o_link      = id_ex_q.ctrl.link;
  assign bus.o_aluOp     = id_ex_q.ctrl.alu_op;
  assign bus.o_link_pc   = id_ex_q.link_pc;

endmodule

// File: tb/tb_id_stage_hz.sv
// Randomised self-checking bench for id_stage_hz against a behavioural ID-stage model.
`timescale 1ns/1ps
module tb_id_stage_hz;

  typedef struct {
    logic [4:0]  rs, rt, rd;
    logic [31:0] da, db, imm;
    logic [4:0]  shamt;
    logic [5:0]  func;
    logic        reg_dst, alu_src, mem2reg, mem_read, mem_write, reg_write, link;
    logic [1:0]  alu_op;
    logic [31:0] link_pc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  logic [31:0] mregs [32];
  bit          model_valid = 1'b0;
  exp_t        exp_q;
  logic        samp_stall, samp_src;
  logic [31:0] samp_target;
  logic [5:0]  op_tbl [13] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0C,
                               6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h3F, 6'h07};

`ifdef ID_BRANCH_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  id_stage_hz_if bus ();

  id_stage_hz dut (
    .clk   (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [31:0] modelRead(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (bus.i_we_wb && bus.i_wr_addr_wb == a) return bus.i_wr_data_wb;
    return mregs[a];
  endfunction

  task automatic modelComb(output logic stall, output logic src, output logic [31:0] target);
    logic [5:0]  op;
    logic [4:0]  rs, rt;
    logic [31:0] a, b, sext;
    bit          is_br, reads_rt, ex_rs, ex_rt, mem_rs, mem_rt;
    op       = bus.i_instruction[31:26];
    rs       = bus.i_instruction[25:21];
    rt       = bus.i_instruction[20:16];
    is_br    = (op == 6'h04) || (op == 6'h05);
    reads_rt = (op == 6'h00) || is_br || (op == 6'h2B);
    ex_rs    = (bus.i_ex_wr_addr != 5'd0) && (bus.i_ex_wr_addr == rs);
    ex_rt    = (bus.i_ex_wr_addr != 5'd0) && (bus.i_ex_wr_addr == rt);
    mem_rs   = (bus.i_mem_wr_addr != 5'd0) && (bus.i_mem_wr_addr == rs);
    mem_rt   = (bus.i_mem_wr_addr != 5'd0) && (bus.i_mem_wr_addr == rt);
    stall    = (bus.i_ex_mem_read && (ex_rs || (reads_rt && ex_rt))) ||
               (is_br && bus.i_ex_reg_write && (ex_rs || ex_rt));
    a = modelRead(rs);
    b = modelRead(rt);
    if (FWD) begin
      if (bus.i_mem_reg_write && mem_rs) a = bus.i_mem_wr_data;
      if (bus.i_mem_reg_write && mem_rt) b = bus.i_mem_wr_data;
    end else if (is_br && bus.i_mem_reg_write && (mem_rs || mem_rt)) begin
      stall = 1'b1;
    end
    sext   = 32'($signed(bus.i_instruction[15:0]));
    src    = 1'b0;
    target = 32'd0;
    if (!stall) begin
      if (op == 6'h04) begin
        src    = (a == b);
        target = bus.i_pcounter4 + (sext << 2);
      end else if (op == 6'h05) begin
        src    = (a != b);
        target = bus.i_pcounter4 + (sext << 2);
      end else if (op == 6'h02 || op == 6'h03) begin
        src    = 1'b1;
        target = (bus.i_pcounter4 & 32'hF000_0000) | ({6'd0, bus.i_instruction[25:0]} << 2);
      end
    end
  endtask

  function automatic exp_t modelDecode();
    exp_t        e;
    logic [5:0]  op;
    logic [15:0] imm;
    e         = '{default: '0};
    op        = bus.i_instruction[31:26];
    imm       = bus.i_instruction[15:0];
    e.rs      = bus.i_instruction[25:21];
    e.rt      = bus.i_instruction[20:16];
    e.rd      = (op == 6'h03) ? 5'd31 : bus.i_instruction[15:11];
    e.da      = modelRead(e.rs);
    e.db      = modelRead(e.rt);
    e.shamt   = bus.i_instruction[10:6];
    e.func    = bus.i_instruction[5:0];
    e.link_pc = bus.i_pcounter4;
    if (op == 6'h0C || op == 6'h0D) e.imm = {16'h0000, imm};
    else if (op == 6'h0F)           e.imm = {imm, 16'h0000};
    else                            e.imm = 32'($signed(imm));
    case (op)
      6'h00: begin e.reg_dst = 1; e.reg_write = 1; e.alu_op = 2'b10; end
      6'h03: begin e.link = 1; e.reg_write = 1; end
      6'h04, 6'h05: e.alu_op = 2'b01;
      6'h08, 6'h0F: begin e.alu_src = 1; e.reg_write = 1; end
      6'h0C, 6'h0D: begin e.alu_src = 1; e.reg_write = 1; e.alu_op = 2'b11; end
      6'h23: begin e.alu_src = 1; e.mem2reg = 1; e.mem_read = 1; e.reg_write = 1; end
      6'h2B: begin e.alu_src = 1; e.mem_write = 1; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic checkRegs();
    checkOutput("rs", bus.o_rs, exp_q.rs);
    checkOutput("rt", bus.o_rt, exp_q.rt);
    checkOutput("rd", bus.o_rd, exp_q.rd);
    checkOutput("reg_DA", bus.o_reg_DA, exp_q.da);
    checkOutput("reg_DB", bus.o_reg_DB, exp_q.db);
    checkOutput("immediate", bus.o_immediate, exp_q.imm);
    checkOutput("shamt", bus.o_shamt, exp_q.shamt);
    checkOutput("func", bus.o_func, exp_q.func);
    checkOutput("regDst", bus.o_regDst, exp_q.reg_dst);
    checkOutput("aluSrc", bus.o_aluSrc, exp_q.alu_src);
    checkOutput("mem2Reg", bus.o_mem2Reg, exp_q.mem2reg);
    checkOutput("memRead", bus.o_memRead, exp_q.mem_read);
    checkOutput("memWrite", bus.o_memWrite, exp_q.mem_write);
    checkOutput("regWrite", bus.o_regWrite, exp_q.reg_write);
    checkOutput("link", bus.o_link, exp_q.link);
    checkOutput("aluOp", bus.o_aluOp, exp_q.alu_op);
    checkOutput("link_pc", bus.o_link_pc, exp_q.link_pc);
  endtask

  // One clock: sample combinational outputs mid-cycle, then the ID/EX bank after the edge.
  task automatic applyStimulus();
    logic        e_stall, e_src;
    logic [31:0] e_target;
    exp_t        nxt;
    @(negedge clk);
    samp_stall  = bus.o_hz_stall;
    samp_src    = bus.o_pc_src;
    samp_target = bus.o_pc_target;
    modelComb(e_stall, e_src, e_target);
    if (model_valid) begin
      checkOutput("hz_stall", samp_stall, e_stall);
      checkOutput("pc_src", samp_src, e_src);
      if (e_src) checkOutput("pc_target", samp_target, e_target);
    end
    if (rst || bus.i_flush || e_stall) nxt = '{default: '0};
    else if (bus.i_stall)              nxt = exp_q;
    else                               nxt = modelDecode();
    @(posedge clk);
    if (rst) begin
      foreach (mregs[i]) mregs[i] = 32'd0;
      model_valid = 1'b1;
    end else if (bus.i_we_wb && bus.i_wr_addr_wb != 5'd0) begin
      mregs[bus.i_wr_addr_wb] = bus.i_wr_data_wb;
    end
    exp_q = nxt;
    #1;
    if (model_valid) checkRegs();
  endtask

  task automatic setIdle();
    bus.i_instruction   = 32'd0;
    bus.i_pcounter4     = 32'd0;
    bus.i_stall         = 1'b0;
    bus.i_flush         = 1'b0;
    bus.i_we_wb         = 1'b0;
    bus.i_wr_addr_wb    = 5'd0;
    bus.i_wr_data_wb    = 32'd0;
    bus.i_ex_mem_read   = 1'b0;
    bus.i_ex_reg_write  = 1'b0;
    bus.i_ex_wr_addr    = 5'd0;
    bus.i_mem_reg_write = 1'b0;
    bus.i_mem_wr_addr   = 5'd0;
    bus.i_mem_wr_data   = 32'd0;
  endtask

  initial begin
    logic [31:0] w;
    exp_q = '{default: '0};
    foreach (mregs[i]) mregs[i] = 32'd0;
    setIdle();
    rst = 1'b1;
    applyStimulus();
    applyStimulus();
    rst = 1'b0;

    // Write-through on r5, and r0 stays zero even when written.
    bus.i_we_wb = 1; bus.i_wr_addr_wb = 5'd5; bus.i_wr_data_wb = 32'h1234;
    bus.i_instruction = {6'h00, 5'd5, 5'd0, 5'd7, 5'd0, 6'h20};
    applyStimulus();
    checkOutput("wt_reg_DA", bus.o_reg_DA, 32'h0000_1234);
    bus.i_wr_addr_wb = 5'd0; bus.i_wr_data_wb = 32'hDEAD_BEEF;
    bus.i_instruction = {6'h00, 5'd0, 5'd0, 5'd7, 5'd0, 6'h20};
    applyStimulus();
    checkOutput("r0_wt_DA", bus.o_reg_DA, 32'd0);
    setIdle();
    applyStimulus();
    checkOutput("r0_read_DA", bus.o_reg_DA, 32'd0);

    // Load-use: LW r2 in EX, ADD r3,r2,r4 in ID.
    bus.i_instruction = {6'h00, 5'd2, 5'd4, 5'd3, 5'd0, 6'h20};
    bus.i_ex_mem_read = 1; bus.i_ex_reg_write = 1; bus.i_ex_wr_addr = 5'd2;
    applyStimulus();
    checkOutput("lu_stall", samp_stall, 1'b1);
    checkOutput("lu_bubble", bus.o_regWrite, 1'b0);
    bus.i_ex_mem_read = 0; bus.i_ex_reg_write = 0; bus.i_ex_wr_addr = 5'd0;
    applyStimulus();
    checkOutput("lu_release", samp_stall, 1'b0);
    checkOutput("lu_load_rw", bus.o_regWrite, 1'b1);
    checkOutput("lu_load_rd", bus.o_rd, 5'd3);

    // BEQ r1,r1,+4 taken; BNE with equal operands not taken.
    bus.i_instruction = {6'h04, 5'd1, 5'd1, 16'd4}; bus.i_pcounter4 = 32'h100;
    applyStimulus();
    checkOutput("beq_src", samp_src, 1'b1);
    checkOutput("beq_target", samp_target, 32'h110);
    bus.i_instruction = {6'h05, 5'd1, 5'd1, 16'd4};
    applyStimulus();
    checkOutput("bne_eq_src", samp_src, 1'b0);

    // BNE r6,r0 with MEM writing r6 (r6 holds 0 in the bank).
    bus.i_instruction = {6'h05, 5'd6, 5'd0, 16'd8};
    bus.i_mem_reg_write = 1; bus.i_mem_wr_addr = 5'd6; bus.i_mem_wr_data = 32'h55;
    applyStimulus();
    checkOutput("mem_br_stall", samp_stall, !FWD);
    checkOutput("mem_br_src", samp_src, FWD);
    setIdle();

    // JAL at pcounter4 0x2000_0004.
    bus.i_instruction = {6'h03, 26'h40}; bus.i_pcounter4 = 32'h2000_0004;
    applyStimulus();
    checkOutput("jal_target", samp_target, 32'h2000_0100);
    checkOutput("jal_link", bus.o_link, 1'b1);
    checkOutput("jal_rd", bus.o_rd, 5'd31);
    checkOutput("jal_link_pc", bus.o_link_pc, 32'h2000_0004);

    // ORI zero-extends.
    bus.i_instruction = {6'h0D, 5'd1, 5'd2, 16'hFFFF};
    applyStimulus();
    checkOutput("ori_imm", bus.o_immediate, 32'h0000_FFFF);

    // Flush together with stall gives a bubble, not a hold.
    bus.i_flush = 1; bus.i_stall = 1;
    bus.i_instruction = {6'h08, 5'd1, 5'd2, 16'h0010};
    applyStimulus();
    checkOutput("flush_stall_rw", bus.o_regWrite, 1'b0);
    checkOutput("flush_stall_imm", bus.o_immediate, 32'd0);
    bus.i_flush = 0; bus.i_stall = 0;

    // Mid-stream reset clears ID/EX and the bank.
    applyStimulus();
    rst = 1;
    applyStimulus();
    checkOutput("rst_rw", bus.o_regWrite, 1'b0);
    checkOutput("rst_imm", bus.o_immediate, 32'd0);
    rst = 0;
    bus.i_instruction = {6'h00, 5'd5, 5'd0, 5'd7, 5'd0, 6'h20};
    applyStimulus();
    checkOutput("rst_r5", bus.o_reg_DA, 32'd0);

    for (int n = 0; n < 400; n++) begin
      w        = $urandom();
      w[31:26] = op_tbl[$urandom_range(0, 12)];
      w[25:21] = 5'($urandom_range(0, 7));
      w[20:16] = 5'($urandom_range(0, 7));
      w[15:11] = 5'($urandom_range(0, 7));
      bus.i_instruction   = w;
      bus.i_pcounter4     = $urandom() & 32'hFFFF_FFFC;
      rst                 = ($urandom_range(0, 63) == 0);
      bus.i_flush         = ($urandom_range(0, 9) == 0);
      bus.i_stall         = ($urandom_range(0, 5) == 0);
      bus.i_we_wb         = 1'($urandom_range(0, 1));
      bus.i_wr_addr_wb    = 5'($urandom_range(0, 7));
      bus.i_wr_data_wb    = $urandom_range(0, 3);
      bus.i_ex_mem_read   = ($urandom_range(0, 3) == 0);
      bus.i_ex_reg_write  = 1'($urandom_range(0, 1));
      bus.i_ex_wr_addr    = 5'($urandom_range(0, 7));
      bus.i_mem_reg_write = 1'($urandom_range(0, 1));
      bus.i_mem_wr_addr   = 5'($urandom_range(0, 7));
      bus.i_mem_wr_data   = $urandom_range(0, 3);
      applyStimulus();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
